hsv_core_issue_sched: RTL and testbench



---
 rtl/hsv_core_issue_sched.sv | 94 +++++++++
 tb/tb_hsv_core_issue_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_issue_sched.sv
// Issue scheduler: scoreboard + in-flight limit, releases one decoded op per cycle to a one-hot unit.
// Zero-cycle issue; ready_o drops on hazard, full, serialization, unit backpressure or flush.
module hsv_core_issue_sched #(
  parameter int MAX_INFLIGHT = 8,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic       clk_core,
  input  logic       rst_core_n,
  input  logic       flush_req,
  output logic       flush_ack,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [4:0] exec_select_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       uses_rs1_i,
  input  logic       uses_rs2_i,
  input  logic       writes_rd_i,
  output logic [4:0] unit_valid_o,
  input  logic [4:0] unit_ready_i,
  input  logic       retire_valid_i,
  input  logic [4:0] retire_rd_i,
  input  logic       retire_writes_rd_i,
  output logic       idle_o
);

  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_nxt;
  logic          flush_q;

  logic flushing;
  logic raw;
  logic waw;
  logic full;
  logic serial;
  logic can_issue;
  logic fire;

  // Hazards look only at registered state; a retire this cycle helps next cycle.
  assign flushing  = flush_req | flush_q;
  assign raw       = (uses_rs1_i & busy[rs1_i]) | (uses_rs2_i & busy[rs2_i]);
  assign waw       = writes_rd_i & busy[rd_i];
  assign full      = (inflight == CW'(MAX_INFLIGHT));
  assign serial    = exec_select_i[4] & (inflight != '0);
  assign can_issue = ~flushing & ~raw & ~waw & ~full & ~serial
                   & (|(exec_select_i & unit_ready_i));
  assign fire      = valid_i & can_issue;

  assign ready_o      = can_issue;
  assign unit_valid_o = fire ? exec_select_i : 5'd0;
  assign flush_ack    = flush_q;
  assign idle_o       = (inflight == '0);

  always_comb begin
    busy_nxt = busy;
    if (flushing) begin
      busy_nxt = '0;
    end else begin
      if (retire_valid_i && retire_writes_rd_i && (retire_rd_i != 5'd0))
        busy_nxt[retire_rd_i] = 1'b0;
      // Set after clear so a new writer wins over a same-index retire.
      if (fire && writes_rd_i && (rd_i != 5'd0))
        busy_nxt[rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    inflight_nxt = inflight;
    if (flushing) begin
      inflight_nxt = '0;
    end else if (fire && !retire_valid_i) begin
      inflight_nxt = inflight + CW'(1);
    end else if (!fire && retire_valid_i && (inflight != '0)) begin
      inflight_nxt = inflight - CW'(1);
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      busy     <= '0;
      inflight <= '0;
      flush_q  <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      inflight <= inflight_nxt;
      flush_q  <= flush_req;
    end
  end

endmodule

// File: tb/tb_hsv_core_issue_sched.sv
// Directed test-plan scenarios followed by a randomized run, all against a behavioural scoreboard model.
module tb_hsv_core_issue_sched;
  localparam int MAXI = 8;

  logic       clk_core = 1'b0;
  logic       rst_core_n = 1'b0;
  logic       flush_req = 1'b0;
  logic       flush_ack;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [4:0] exec_select_i = 5'd1;
  logic [4:0] rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic       uses_rs1_i = 1'b0, uses_rs2_i = 1'b0, writes_rd_i = 1'b0;
  logic [4:0] unit_valid_o;
  logic [4:0] unit_ready_i = 5'b11111;
  logic       retire_valid_i = 1'b0;
  logic [4:0] retire_rd_i = '0;
  logic       retire_writes_rd_i = 1'b0;
  logic       idle_o;

  hsv_core_issue_sched #(.MAX_INFLIGHT(MAXI)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .valid_i(valid_i), .ready_o(ready_o), .exec_select_i(exec_select_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i), .writes_rd_i(writes_rd_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .retire_valid_i(retire_valid_i), .retire_rd_i(retire_rd_i),
    .retire_writes_rd_i(retire_writes_rd_i), .idle_o(idle_o)
  );

  always #5 clk_core = ~clk_core;

  int checks = 0;
  int failures = 0;

  // Reference model: set of pending destinations, outstanding count, delayed flush.
  bit [31:0] busy_m;
  int        infl_m;
  bit        fq_m;
  bit        last_fire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_issue();
    bit hazard_raw, hazard_waw, unit_ok;
    hazard_raw = (uses_rs1_i && busy_m[rs1_i]) || (uses_rs2_i && busy_m[rs2_i]);
    hazard_waw = writes_rd_i && busy_m[rd_i];
    unit_ok    = (exec_select_i & unit_ready_i) != 5'd0;
    return !flush_req && !fq_m && !hazard_raw && !hazard_waw && (infl_m < MAXI)
           && !(exec_select_i[4] && infl_m > 0) && unit_ok;
  endfunction

  task automatic model_reset();
    busy_m = '0;
    infl_m = 0;
    fq_m   = 1'b0;
  endtask

  // Compare the current cycle against the model, advance the model, move to next negedge.
  task automatic step(input string tag);
    bit ci, fire;
    #1;
    ci   = exp_issue();
    fire = ci && valid_i;
    chk({tag, ":rdy"},  {31'd0, ready_o}, {31'd0, ci});
    chk({tag, ":uv"},   {27'd0, unit_valid_o}, fire ? {27'd0, exec_select_i} : 32'd0);
    chk({tag, ":ack"},  {31'd0, flush_ack}, {31'd0, fq_m});
    chk({tag, ":idle"}, {31'd0, idle_o}, (infl_m == 0) ? 32'd1 : 32'd0);
    if (flush_req || fq_m) begin
      busy_m = '0;
      infl_m = 0;
    end else begin
      if (retire_valid_i && retire_writes_rd_i && retire_rd_i != 5'd0) busy_m[retire_rd_i] = 1'b0;
      if (fire && writes_rd_i && rd_i != 5'd0) busy_m[rd_i] = 1'b1;
      if (fire && !retire_valid_i) infl_m++;
      else if (!fire && retire_valid_i && infl_m > 0) infl_m--;
    end
    fq_m      = flush_req;
    last_fire = fire;
    @(negedge clk_core);
  endtask

  // Explicit test-plan expectation on the current cycle's combinational outputs.
  task automatic xp(input string tag, input logic r, input logic [4:0] uv);
    #1;
    chk({tag, ":rdy"}, {31'd0, ready_o}, {31'd0, r});
    chk({tag, ":uv"},  {27'd0, unit_valid_o}, {27'd0, uv});
  endtask

  task automatic instr(input logic [4:0] sel, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub, input logic [4:0] d, input logic w);
    valid_i = 1'b1; exec_select_i = sel;
    rs1_i = a; uses_rs1_i = ua; rs2_i = b; uses_rs2_i = ub; rd_i = d; writes_rd_i = w;
  endtask

  task automatic ret(input logic v, input logic [4:0] d, input logic w);
    retire_valid_i = v; retire_rd_i = d; retire_writes_rd_i = w;
  endtask

  task automatic do_reset();
    rst_core_n = 1'b0;
    valid_i = 1'b0; flush_req = 1'b0; unit_ready_i = 5'b11111;
    ret(1'b0, 5'd0, 1'b0);
    #1;
    chk("rst:idle", {31'd0, idle_o}, 32'd1);
    chk("rst:ack",  {31'd0, flush_ack}, 32'd0);
    model_reset();
    @(negedge clk_core);
    rst_core_n = 1'b1;
  endtask

  initial begin
    int flush_cnt;
    do_reset();

    // RAW stall released the cycle after retire
    instr(5'b00001, 0, 0, 0, 0, 5, 1); xp("raw_alu", 1, 5'b00001); step("raw_alu");
    instr(5'b00100, 5, 1, 0, 0, 0, 0); xp("raw_s0", 0, 0); step("raw_s0");
    xp("raw_s1", 0, 0); step("raw_s1");
    ret(1, 5, 1); xp("raw_ret", 0, 0); step("raw_ret");
    ret(0, 0, 0); xp("raw_go", 1, 5'b00100); step("raw_go");

    // x0 writes never stall; WAW on x7; same-cycle retire+set leaves x7 busy
    do_reset();
    instr(5'b00001, 0, 0, 0, 0, 0, 1); xp("x0_a", 1, 5'b00001); step("x0_a");
    xp("x0_b", 1, 5'b00001); step("x0_b");
    instr(5'b00001, 0, 0, 0, 0, 7, 1); xp("waw_a", 1, 5'b00001); step("waw_a");
    xp("waw_b", 0, 0); step("waw_b");
    ret(1, 7, 1); xp("waw_r", 0, 0); step("waw_r");
    ret(0, 0, 0); xp("waw_go", 1, 5'b00001); step("waw_go");
    valid_i = 1'b0; ret(1, 7, 1); step("waw_clr");
    instr(5'b00001, 0, 0, 0, 0, 7, 1); xp("same_go", 1, 5'b00001); step("same_go");
    ret(0, 0, 0); instr(5'b00001, 7, 1, 0, 0, 0, 0); xp("same_busy", 0, 0); step("same_busy");

    // In-flight limit
    do_reset();
    instr(5'b00001, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin xp("lim_fill", 1, 5'b00001); step("lim_fill"); end
    ret(1, 0, 0); xp("lim_both", 1, 5'b00001); step("lim_both");
    ret(0, 0, 0); xp("lim_8th", 1, 5'b00001); step("lim_8th");
    xp("lim_full", 0, 0); step("lim_full");
    ret(1, 0, 0); xp("lim_full_ret", 0, 0); step("lim_full_ret");
    ret(0, 0, 0); xp("lim_ninth", 1, 5'b00001); step("lim_ninth");

    // Serialization of ctrlstatus
    do_reset();
    instr(5'b00001, 0, 0, 0, 0, 0, 0); step("ser_p0"); step("ser_p1");
    instr(5'b10000, 0, 0, 0, 0, 0, 0); xp("ser_s0", 0, 0); step("ser_s0");
    ret(1, 0, 0); xp("ser_s1", 0, 0); step("ser_s1");
    xp("ser_s2", 0, 0); step("ser_s2");
    ret(0, 0, 0); xp("ser_go", 1, 5'b10000);
    chk("ser_idle", {31'd0, idle_o}, 32'd1); step("ser_go");

    // Unit backpressure
    do_reset();
    unit_ready_i = 5'b11101;
    instr(5'b00010, 0, 0, 0, 0, 0, 0); xp("bp_blk", 0, 0);
    unit_ready_i = 5'b11111; xp("bp_go", 1, 5'b00010); step("bp_go");

    // Flush window with x3, x9 busy and two in flight
    do_reset();
    instr(5'b00001, 0, 0, 0, 0, 3, 1); step("fl_p0");
    instr(5'b00001, 0, 0, 0, 0, 9, 1); step("fl_p1");
    instr(5'b00001, 3, 1, 9, 1, 0, 0); xp("fl_pre", 0, 0);
    flush_req = 1'b1; xp("fl_w0", 0, 0); chk("fl_w0:ack", {31'd0, flush_ack}, 32'd0); step("fl_w0");
    xp("fl_w1", 0, 0); chk("fl_w1:ack", {31'd0, flush_ack}, 32'd1); step("fl_w1");
    flush_req = 1'b0; xp("fl_w2", 0, 0); chk("fl_w2:ack", {31'd0, flush_ack}, 32'd1); step("fl_w2");
    xp("fl_after", 1, 5'b00001);
    chk("fl_after:ack", {31'd0, flush_ack}, 32'd0);
    chk("fl_after:idle", {31'd0, idle_o}, 32'd1); step("fl_after");

    // Asynchronous reset mid-stream
    instr(5'b00001, 0, 0, 0, 0, 4, 1); step("ar_p0");
    instr(5'b00001, 4, 1, 0, 0, 0, 0); xp("ar_pre", 0, 0);
    rst_core_n = 1'b0; #1;
    chk("ar:idle", {31'd0, idle_o}, 32'd1);
    chk("ar:rdy",  {31'd0, ready_o}, 32'd1);
    model_reset();
    @(negedge clk_core);
    rst_core_n = 1'b1;

    // Randomized run against the model
    valid_i = 1'b0; flush_cnt = 0; last_fire = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (!valid_i || last_fire || flush_req) begin
        if ($urandom_range(0, 9) < 7)
          instr(5'(1 << $urandom_range(0, 4)), 5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
        else
          valid_i = 1'b0;
      end
      if (flush_cnt > 0) begin
        flush_req = 1'b1; flush_cnt--;
      end else if ($urandom_range(0, 99) < 3) begin
        flush_req = 1'b1; flush_cnt = $urandom_range(0, 2);
      end else begin
        flush_req = 1'b0;
      end
      if ((infl_m > 0 && $urandom_range(0, 9) < 4) || $urandom_range(0, 99) == 0)
        ret(1, 5'($urandom_range(0, 7)), 1'($urandom));
      else
        ret(0, 0, 0);
      for (int u = 0; u < 5; u++) unit_ready_i[u] = ($urandom_range(0, 9) < 8);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
